// File: rtl/ps2_key_tracker.sv
// -----------------------------------------------------------------------------
// ps2_key_tracker
//   Decodes PS/2 make / break / E0-extended scan-code sequences for a table of
//   keys, keeps a live pressed bitmap, drops typematic repeats and queues
//   press/release events in a FIFO that is drained over a registered bus port.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_rx_data      received scan-code byte (already in i_clk domain)
//   i_rx_valid     one-cycle strobe qualifying i_rx_data
//   i_rd_en        bus read strobe
//   i_addr         read register: 0 bitmap, 1 pop, 2 status, 3 zero
//   o_rd_data      registered read data
//   o_rd_valid     pulses the cycle after i_rd_en
//   o_key_state    live pressed bitmap, bit i = table entry i
//   o_evt_pending  event FIFO not empty
// -----------------------------------------------------------------------------
module ps2_key_tracker #(
   parameter int                    NUM_KEYS   = 10,
   parameter logic [9*NUM_KEYS-1:0] KEY_CODES  = '0,
   parameter int                    FIFO_DEPTH = 8,
   parameter int                    BUS_WIDTH  = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [7:0]           i_rx_data,
   input  logic                 i_rx_valid,
   input  logic                 i_rd_en,
   input  logic [1:0]           i_addr,
   output logic [BUS_WIDTH-1:0] o_rd_data,
   output logic                 o_rd_valid,
   output logic [NUM_KEYS-1:0]  o_key_state,
   output logic                 o_evt_pending
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int KW = (NUM_KEYS < BUS_WIDTH) ? NUM_KEYS : BUS_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   state_t               r_state, w_state_nxt;
   logic                 w_make, w_brk, w_ext;
   logic [NUM_KEYS-1:0]  w_hit_vec, w_set, w_clr;
   logic [4:0]           w_idx;
   logic                 w_push;
   logic [5:0]           w_evt;

   logic [NUM_KEYS-1:0]  r_key_state;
   logic [5:0]           r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [6:0]           r_count;
   logic                 r_ovf;
   logic                 w_full, w_empty, w_pop, w_wr, w_ovf_set;

   logic [BUS_WIDTH-1:0] w_rd_nxt, r_rd_data;
   logic                 r_rd_valid;

   // ---------------- parser FSM: state register ----------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   // ---------------- parser FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      if (i_rx_valid) begin
         case (r_state)
            S_IDLE: begin
               if      (i_rx_data == 8'hE0) w_state_nxt = S_EXT;
               else if (i_rx_data == 8'hF0) w_state_nxt = S_BRK;
               else                         w_state_nxt = S_IDLE;
            end
            S_EXT: begin
               if      (i_rx_data == 8'hF0) w_state_nxt = S_EXT_BRK;
               else if (i_rx_data == 8'hE0) w_state_nxt = S_EXT;
               else                         w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;  // BRK / EXT_BRK consume one byte
         endcase
      end
   end

   // ---------------- parser FSM: outputs (make/break decode) ----------------
   always_comb begin
      w_make = 1'b0;
      w_brk  = 1'b0;
      w_ext  = 1'b0;
      if (i_rx_valid) begin
         case (r_state)
            S_IDLE: begin
               // prefixes, keyboard replies (ACK/BAT/echo/resend/error) and
               // the E1 pause prefix never name a key
               case (i_rx_data)
                  8'hE0, 8'hF0, 8'hFA, 8'hAA, 8'hEE,
                  8'hFE, 8'h00, 8'hFF, 8'hE1: w_make = 1'b0;
                  default:                    w_make = 1'b1;
               endcase
            end
            S_EXT: begin
               w_ext  = 1'b1;
               w_make = (i_rx_data != 8'hF0) && (i_rx_data != 8'hE0);
            end
            S_BRK:     w_brk = 1'b1;
            S_EXT_BRK: begin
               w_brk = 1'b1;
               w_ext = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- key table lookup ----------------
   // Entries are unique, so at most one hit; the index loop needs no priority.
   always_comb begin
      w_hit_vec = '0;
      w_idx     = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (KEY_CODES[9*i +: 9] == {w_ext, i_rx_data}) begin
            w_hit_vec[i] = 1'b1;
            w_idx        = 5'(i);
         end
      end
   end

   // Only real transitions produce events; repeats and stray breaks fall out.
   assign w_set  = w_make ? (w_hit_vec & ~r_key_state) : '0;
   assign w_clr  = w_brk  ? (w_hit_vec &  r_key_state) : '0;
   assign w_push = |(w_set | w_clr);
   assign w_evt  = {w_make, w_idx};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_key_state <= '0;
      else            r_key_state <= (r_key_state | w_set) & ~w_clr;
   end

   // ---------------- event FIFO ----------------
   assign w_full    = (r_count == 7'(FIFO_DEPTH));
   assign w_empty   = (r_count == 7'd0);
   assign w_pop     = i_rd_en && (i_addr == 2'd1) && !w_empty;
   // A pop in the same cycle frees the slot being written (wr_ptr == rd_ptr
   // when full); the read captures the old entry at this edge.
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && w_full && !w_pop;

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_evt;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 7'd1;
            2'b01:   r_count <= r_count - 7'd1;
            default: ;
         endcase
         // a new overflow beats the clear-on-read of the status register
         if (w_ovf_set)                          r_ovf <= 1'b1;
         else if (i_rd_en && (i_addr == 2'd2))   r_ovf <= 1'b0;
      end
   end

   // ---------------- bus read port ----------------
   always_comb begin
      w_rd_nxt = '0;
      if (i_rd_en) begin
         case (i_addr)
            2'd0: w_rd_nxt[KW-1:0] = r_key_state[KW-1:0];
            2'd1: if (!w_empty) begin
               w_rd_nxt[15]  = 1'b1;
               w_rd_nxt[5:0] = r_mem[r_rd_ptr];
            end
            2'd2: begin
               w_rd_nxt[6:0] = r_count;
               w_rd_nxt[8]   = r_ovf;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_data  <= w_rd_nxt;
         r_rd_valid <= i_rd_en;
      end
   end

   assign o_rd_data     = r_rd_data;
   assign o_rd_valid    = r_rd_valid;
   assign o_key_state   = r_key_state;
   assign o_evt_pending = !w_empty;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

   localparam int NK = 10;
   // entry 0 = 024, entry 5 = E0 75, the rest ordinary single-byte codes
   localparam logic [9*NK-1:0] CODES = {9'h042, 9'h03B, 9'h033, 9'h034, 9'h175,
                                        9'h02B, 9'h023, 9'h01B, 9'h01C, 9'h024};

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rd_en;
   logic [1:0]    addr;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic [NK-1:0] key_state;
   logic          evt_pending;

   int n_pass  = 0;
   int n_total = 0;

   logic [5:0] sb [$];   // expected events, oldest first

   ps2_key_tracker #(.NUM_KEYS(NK), .KEY_CODES(CODES), .FIFO_DEPTH(8), .BUS_WIDTH(32)) dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_rd_en(rd_en), .i_addr(addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
      .o_key_state(key_state), .o_evt_pending(evt_pending));

   always #5 clk = ~clk;

   // One bus cycle starting at a negedge: drive, sample 1 after the posedge,
   // return at the next negedge with strobes dropped.
   task automatic cyc(input logic v, input logic [7:0] b, input logic r, input logic [1:0] a,
                      output logic [31:0] d, output logic dv);
      rx_valid = v; rx_data = b; rd_en = r; addr = a;
      @(posedge clk); #1;
      d = rd_data; dv = rd_valid;
      @(negedge clk);
      rx_valid = 1'b0; rd_en = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      logic [31:0] d; logic dv;
      cyc(1'b1, b, 1'b0, 2'd0, d, dv);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic dv);
      cyc(1'b0, 8'h00, 1'b1, a, d, dv);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      sb.delete();
   endtask

   function automatic logic [31:0] pop_word(input logic [5:0] ev);
      return 32'h8000 | 32'(ev);
   endfunction

   task automatic test_reset();
      logic [31:0] d; logic dv;
      reset_n = 1'b0;
      @(negedge clk); #1;
      n_total++;
      if ({rd_data, rd_valid, evt_pending, key_state} !== '0)
         $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b pend=%b ks=%h, want all 0",
                  rd_data, rd_valid, evt_pending, key_state);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 3; a++) begin
         rd(2'(a), d, dv);
         n_total++;
         if (d !== 32'h0 || dv !== 1'b1)
            $display("FAIL reset_read%0d: got %h valid=%b, want 0 valid=1", a, d, dv);
         else n_pass++;
      end
      n_total++;
      if (evt_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", evt_pending);
      else n_pass++;
   endtask

   task automatic test_make_break();
      logic [31:0] d, e; logic dv;
      do_reset();
      send(8'h24); sb.push_back({1'b1, 5'd0});
      n_total++;
      if (key_state !== 10'h001 || evt_pending !== 1'b1)
         $display("FAIL make0: got ks=%h pend=%b, want ks=001 pend=1", key_state, evt_pending);
      else n_pass++;
      send(8'h24); send(8'h24);          // typematic repeats
      send(8'hF0); send(8'h24); sb.push_back({1'b0, 5'd0});
      n_total++;
      if (key_state !== 10'h000) $display("FAIL break0: got ks=%h want 000", key_state);
      else n_pass++;
      rd(2'd2, d, dv);
      n_total++;
      if (d !== 32'h002) $display("FAIL mb_status: got %h want 00000002", d);
      else n_pass++;
      while (sb.size() > 0) begin
         rd(2'd1, d, dv); e = pop_word(sb.pop_front());
         n_total++;
         if (d !== e) $display("FAIL mb_pop: got %h want %h", d, e);
         else n_pass++;
      end
      rd(2'd1, d, dv);
      n_total++;
      if (d !== 32'h0 || evt_pending !== 1'b0)
         $display("FAIL mb_empty_pop: got %h pend=%b want 0 pend=0", d, evt_pending);
      else n_pass++;
   endtask

   task automatic test_extended();
      logic [31:0] d, e; logic dv;
      do_reset();
      send(8'hE0); send(8'h75); sb.push_back({1'b1, 5'd5});
      n_total++;
      if (key_state !== 10'h020) $display("FAIL ext_make: got ks=%h want 020", key_state);
      else n_pass++;
      send(8'h75); send(8'hFA); send(8'h11);   // non-extended 75, ACK, unknown key
      n_total++;
      if (key_state !== 10'h020) $display("FAIL ext_nochange: got ks=%h want 020", key_state);
      else n_pass++;
      send(8'hE0); send(8'hF0); send(8'h75); sb.push_back({1'b0, 5'd5});
      n_total++;
      if (key_state !== 10'h000) $display("FAIL ext_break: got ks=%h want 000", key_state);
      else n_pass++;
      rd(2'd2, d, dv);
      n_total++;
      if (d !== 32'h002) $display("FAIL ext_status: got %h want 00000002", d);
      else n_pass++;
      while (sb.size() > 0) begin
         rd(2'd1, d, dv); e = pop_word(sb.pop_front());
         n_total++;
         if (d !== e) $display("FAIL ext_pop: got %h want %h", d, e);
         else n_pass++;
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] d, e; logic dv;
      do_reset();
      cyc(1'b1, 8'h1C, 1'b1, 2'd0, d, dv); sb.push_back({1'b1, 5'd1});
      n_total++;
      if (d !== 32'h0 || key_state !== 10'h002)
         $display("FAIL addr0_preupdate: got rd=%h ks=%h want rd=0 ks=002", d, key_state);
      else n_pass++;
      cyc(1'b1, 8'hF0, 1'b1, 2'd3, d, dv);
      n_total++;
      if (d !== 32'h0 || dv !== 1'b1) $display("FAIL addr3: got %h valid=%b want 0 valid=1", d, dv);
      else n_pass++;
      send(8'h1C); sb.push_back({1'b0, 5'd1});
      while (sb.size() > 0) begin
         rd(2'd1, d, dv); e = pop_word(sb.pop_front());
         n_total++;
         if (d !== e) $display("FAIL sc_pop: got %h want %h", d, e);
         else n_pass++;
      end
   endtask

   // keys 0..4,6..9 as plain single-byte codes
   logic [7:0] plain [9] = '{8'h24, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
   int         pidx  [9] = '{0, 1, 2, 3, 4, 6, 7, 8, 9};

   task automatic test_overflow();
      logic [31:0] d, e; logic dv;
      do_reset();
      for (int i = 0; i < 9; i++) begin   // back-to-back strobes
         send(plain[i]);
         if (i < 8) sb.push_back({1'b1, 5'(pidx[i])});
      end
      n_total++;
      if (key_state !== 10'h3DF) $display("FAIL ovf_ks: got %h want 3df", key_state);
      else n_pass++;
      rd(2'd2, d, dv);
      n_total++;
      if (d !== 32'h108) $display("FAIL ovf_status1: got %h want 00000108", d);
      else n_pass++;
      rd(2'd2, d, dv);
      n_total++;
      if (d !== 32'h008) $display("FAIL ovf_status2: got %h want 00000008", d);
      else n_pass++;
      // overflow raised in the same cycle as a status read must survive it
      send(8'hE0);
      cyc(1'b1, 8'h75, 1'b1, 2'd2, d, dv);
      n_total++;
      if (d !== 32'h008 || key_state !== 10'h3FF)
         $display("FAIL ovf_race_read: got rd=%h ks=%h want rd=8 ks=3ff", d, key_state);
      else n_pass++;
      rd(2'd2, d, dv);
      n_total++;
      if (d !== 32'h108) $display("FAIL ovf_race_sticky: got %h want 00000108", d);
      else n_pass++;
      rd(2'd2, d, dv);
      n_total++;
      if (d !== 32'h008) $display("FAIL ovf_race_clear: got %h want 00000008", d);
      else n_pass++;
      while (sb.size() > 0) begin
         rd(2'd1, d, dv); e = pop_word(sb.pop_front());
         n_total++;
         if (d !== e) $display("FAIL ovf_drain: got %h want %h", d, e);
         else n_pass++;
      end
      rd(2'd1, d, dv);
      n_total++;
      if (d !== 32'h0) $display("FAIL ovf_empty: got %h want 0", d);
      else n_pass++;
   endtask

   task automatic test_pop_push_full();
      logic [31:0] d, e; logic dv;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(plain[i]);
         sb.push_back({1'b1, 5'(pidx[i])});
      end
      cyc(1'b1, 8'h42, 1'b1, 2'd1, d, dv);
      e = pop_word(sb.pop_front());
      sb.push_back({1'b1, 5'd9});
      n_total++;
      if (d !== e) $display("FAIL ppf_pop: got %h want %h", d, e);
      else n_pass++;
      rd(2'd2, d, dv);
      n_total++;
      if (d !== 32'h008) $display("FAIL ppf_status: got %h want 00000008", d);
      else n_pass++;
      while (sb.size() > 0) begin
         rd(2'd1, d, dv); e = pop_word(sb.pop_front());
         n_total++;
         if (d !== e) $display("FAIL ppf_drain: got %h want %h", d, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midseq();
      logic [31:0] d, e; logic dv;
      do_reset();
      send(8'hE0); send(8'hF0);
      do_reset();
      send(8'h24); sb.push_back({1'b1, 5'd0});
      n_total++;
      if (key_state !== 10'h001) $display("FAIL midseq_ks: got %h want 001", key_state);
      else n_pass++;
      rd(2'd1, d, dv); e = pop_word(sb.pop_front());
      n_total++;
      if (d !== e) $display("FAIL midseq_pop: got %h want %h", d, e);
      else n_pass++;
   endtask

   initial begin
      reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rd_en = 1'b0; addr = 2'd0;
      @(negedge clk);
      test_reset();
      test_make_break();
      test_extended();
      test_same_cycle();
      test_overflow();
      test_pop_push_full();
      test_reset_midseq();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
